// File: rtl/iir_out_decimator_if.sv
// iir_out_decimator_if: sample input, decimated FWFT output handshake and status flags
interface iir_out_decimator_if #(parameter int DATA_W = 16);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              fifo_full;
  logic              drop;
`ifdef IIR_DEC_DROP_CNT_EN
  logic [7:0]        drop_cnt;
`endif
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, fifo_full, drop
`ifdef IIR_DEC_DROP_CNT_EN
    , input drop_cnt
`endif
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, fifo_full, drop
`ifdef IIR_DEC_DROP_CNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/iir_out_decimator.sv
// iir_out_decimator: block-average decimator feeding a FWFT FIFO with sticky drop flag.
// Optional IIR_DEC_DROP_CNT_EN adds a saturating 8-bit drop counter.
module iir_out_decimator #(
  parameter int DATA_W     = 16,
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_AW    = 3
) (
  input logic clk,
  input logic rst,
  iir_out_decimator_if.slave bus
);
  localparam int ACC_W = DATA_W + LOG2_DECIM;
  localparam int DEPTH = 1 << FIFO_AW;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum;
  logic [LOG2_DECIM-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [FIFO_AW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [FIFO_AW:0]        occ_q, occ_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d, result;
  logic                    out_valid_q, out_valid_d, full_q, full_d;
  logic                    blk_done, pop, push, lost;
  always_comb begin
    sum         = acc_q + {{LOG2_DECIM{bus.in_data[DATA_W-1]}}, bus.in_data};
    result      = DATA_W'(sum >>> LOG2_DECIM);
    blk_done    = bus.in_valid && (&cnt_q);
    pop         = out_valid_q && bus.out_ready;
    push        = blk_done && (!full_q || pop);
    lost        = blk_done && !push;
    acc_d       = !bus.in_valid ? acc_q : blk_done ? '0 : sum;
    cnt_d       = bus.in_valid ? cnt_q + 1'b1 : cnt_q;
    wr_d        = push ? wr_q + 1'b1 : wr_q;
    rd_d        = pop ? rd_q + 1'b1 : rd_q;
    occ_d       = occ_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    out_valid_d = occ_d != '0;
    full_d      = occ_d == (FIFO_AW+1)'(DEPTH);
    // a push landing on the new head slot bypasses the memory read
    out_data_d  = !out_valid_d ? out_data_q : (push && wr_q == rd_d) ? result : mem_q[rd_d];
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= result;
`ifdef IIR_DEC_DROP_CNT_EN
  logic [7:0] dcnt_q, dcnt_d;
  always_comb dcnt_d = (lost && dcnt_q != 8'hff) ? dcnt_q + 1'b1 : dcnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) dcnt_q <= '0;
    else dcnt_q <= dcnt_d;
  assign bus.drop     = dcnt_q != '0;
  assign bus.drop_cnt = dcnt_q;
`else
  logic drop_q, drop_d;
  always_comb drop_d = drop_q || lost;
  always_ff @(posedge clk or posedge rst)
    if (rst) drop_q <= 1'b0;
    else drop_q <= drop_d;
  assign bus.drop = drop_q;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      occ_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      occ_q       <= occ_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      full_q      <= full_d;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.fifo_full = full_q;
endmodule

// File: tb/tb_iir_out_decimator.sv
// tb_iir_out_decimator: directed scenarios plus randomized run against a queue-based average model
module tb_iir_out_decimator;
  localparam int DATA_W = 16;
  localparam int DECIM  = 4;
  localparam int DEPTH  = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;
  int mq[$];
  int smp[$];
  int m_last;
  bit m_drop;
  int m_dcnt;
  iir_out_decimator_if #(.DATA_W(DATA_W)) bus ();
  iir_out_decimator #(.DATA_W(DATA_W), .LOG2_DECIM(2), .FIFO_AW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic int floor_avg(input int s);
    return (s - (((s % DECIM) + DECIM) % DECIM)) / DECIM;
  endfunction

  function automatic void model_reset();
    mq.delete(); smp.delete(); m_last = 0; m_drop = 0; m_dcnt = 0;
  endfunction

  function automatic void model_step(input bit v, input int d, input bit r);
    bit pop = mq.size() > 0 && r;
    bit was_full = mq.size() == DEPTH;
    if (pop) void'(mq.pop_front());
    if (v) begin
      smp.push_back(d);
      if (smp.size() == DECIM) begin
        int res = floor_avg(smp.sum());
        smp.delete();
        if (!was_full || pop) mq.push_back(res);
        else begin
          m_drop = 1;
          if (m_dcnt < 255) m_dcnt++;
        end
      end
    end
    if (mq.size() > 0) m_last = mq[0];
  endfunction

  task automatic drive(input bit v, input int d, input bit r);
    bus.in_valid  = v;
    bus.in_data   = DATA_W'(d);
    bus.out_ready = r;
    model_step(v, d, r);
    @(posedge clk); #1;
  endtask

  task automatic feed_block(input int val, input bit r);
    for (int i = 0; i < DECIM; i++) drive(1, val, r);
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if ({bus.out_valid, bus.out_data, bus.fifo_full, bus.drop} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b data=%0d full=%0b drop=%0b, want all 0",
               bus.out_valid, $signed(bus.out_data), bus.fifo_full, bus.drop);
    end
`ifdef IIR_DEC_DROP_CNT_EN
    n_tests++;
    if (bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt); end
`endif
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    test_reset();
    drive(1, 4, 1); drive(1, 8, 1); drive(1, 12, 1);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: out_valid=%0b want 0", bus.out_valid); end
    drive(1, 16, 1);
    n_tests++;
    if (bus.out_valid !== 1'b1 || $signed(bus.out_data) !== 16'sd10) begin
      n_fail++; $display("FAIL basic_avg: valid=%0b data=%0d want 1/10", bus.out_valid, $signed(bus.out_data));
    end
    drive(0, 0, 1);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: out_valid=%0b want 0", bus.out_valid); end
  endtask

  task automatic test_extremes();
    int blk [3][4] = '{'{-1, -1, -1, -2}, '{-32768, -32768, -32768, -32768}, '{32767, 32767, 32767, 32767}};
    int want [3] = '{-2, -32768, 32767};
    test_reset();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < DECIM; i++) drive(1, blk[b][i], 1);
      n_tests++;
      if (bus.out_valid !== 1'b1 || int'($signed(bus.out_data)) != want[b]) begin
        n_fail++; $display("FAIL extreme_%0d: valid=%0b data=%0d want 1/%0d", b, bus.out_valid, $signed(bus.out_data), want[b]);
      end
    end
  endtask

  task automatic test_gapped();
    int s [4] = '{6, 12, 6, 5};
    test_reset();
    for (int i = 0; i < DECIM; i++) begin
      drive(0, 99, 1);
      drive(1, s[i], 1);
      if (i < DECIM - 1) begin
        n_tests++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL gapped_early_%0d: out_valid=%0b want 0", i, bus.out_valid); end
      end
    end
    n_tests++;
    if (bus.out_valid !== 1'b1 || $signed(bus.out_data) !== 16'sd7) begin
      n_fail++; $display("FAIL gapped_avg: valid=%0b data=%0d want 1/7", bus.out_valid, $signed(bus.out_data));
    end
  endtask

  task automatic test_full_drop();
    test_reset();
    for (int b = 1; b <= 9; b++) begin
      feed_block(b, 0);
      if (b == 8) begin
        n_tests++;
        if (bus.fifo_full !== 1'b1 || bus.drop !== 1'b0) begin
          n_fail++; $display("FAIL full_after_8: full=%0b drop=%0b want 1/0", bus.fifo_full, bus.drop);
        end
      end
    end
    n_tests++;
    if (bus.drop !== 1'b1 || bus.fifo_full !== 1'b1) begin
      n_fail++; $display("FAIL drop_after_9: drop=%0b full=%0b want 1/1", bus.drop, bus.fifo_full);
    end
`ifdef IIR_DEC_DROP_CNT_EN
    n_tests++;
    if (bus.drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_cnt: got %0d want 1", bus.drop_cnt); end
`endif
    for (int i = 1; i <= DEPTH; i++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || int'($signed(bus.out_data)) != i) begin
        n_fail++; $display("FAIL drain_%0d: valid=%0b data=%0d want 1/%0d", i, bus.out_valid, $signed(bus.out_data), i);
      end
      drive(0, 0, 1);
      if (i == 1) begin
        n_tests++;
        if (bus.fifo_full !== 1'b0) begin n_fail++; $display("FAIL full_clear: full=%0b want 0", bus.fifo_full); end
      end
    end
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.drop !== 1'b1) begin
      n_fail++; $display("FAIL drained_empty: valid=%0b drop=%0b want 0/1", bus.out_valid, bus.drop);
    end
  endtask

  task automatic test_full_pop();
    int got[$];
    int cyc = 0;
    test_reset();
    for (int b = 1; b <= DEPTH; b++) feed_block(b, 0);
    for (int i = 0; i < DECIM - 1; i++) drive(1, 9, 0);
    if (bus.out_valid) got.push_back(int'($signed(bus.out_data)));
    drive(1, 9, 1);
    while (bus.out_valid && cyc < 20) begin
      got.push_back(int'($signed(bus.out_data)));
      drive(0, 0, 1);
      cyc++;
    end
    n_tests++;
    if (got != '{1, 2, 3, 4, 5, 6, 7, 8, 9}) begin
      n_fail++; $display("FAIL full_pop_seq: got %p want 1..9", got);
    end
    n_tests++;
    if (bus.drop !== 1'b0) begin n_fail++; $display("FAIL full_pop_drop: drop=%0b want 0", bus.drop); end
  endtask

  task automatic test_reset_mid();
    test_reset();
    drive(1, 100, 1); drive(1, 100, 1);
    test_reset();
    feed_block(5, 1);
    n_tests++;
    if (bus.out_valid !== 1'b1 || $signed(bus.out_data) !== 16'sd5) begin
      n_fail++; $display("FAIL reset_mid: valid=%0b data=%0d want 1/5", bus.out_valid, $signed(bus.out_data));
    end
  endtask

  task automatic test_random();
    int errs = 0;
    test_reset();
    for (int c = 0; c < 3000; c++) begin
      int pct = ((c / 200) % 3 == 0) ? 5 : ((c / 200) % 3 == 1) ? 50 : 95;
      bit r = $urandom_range(99, 0) < pct;
      bit v = $urandom_range(3, 0) != 0;
      int d = int'($urandom_range(65535, 0)) - 32768;
      drive(v, d, r);
      n_tests++;
      if (bus.out_valid !== (mq.size() > 0) || int'($signed(bus.out_data)) != m_last ||
          bus.fifo_full !== (mq.size() == DEPTH) || bus.drop !== m_drop) begin
        n_fail++; errs++;
        if (errs < 10)
          $display("FAIL random_c%0d: valid=%0b data=%0d full=%0b drop=%0b want %0b/%0d/%0b/%0b", c,
                   bus.out_valid, $signed(bus.out_data), bus.fifo_full, bus.drop,
                   mq.size() > 0, m_last, mq.size() == DEPTH, m_drop);
      end
`ifdef IIR_DEC_DROP_CNT_EN
      n_tests++;
      if (int'(bus.drop_cnt) != m_dcnt) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL random_dcnt_c%0d: got %0d want %0d", c, bus.drop_cnt, m_dcnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_gapped();
    test_full_drop();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
